// File: rtl/seq_divider_16by8.sv
// Iterative restoring divider: N-bit dividend by D-bit divisor, one quotient bit per clock.
// Driven by a start/done handshake; results are held in output registers until the next completion.
module seq_divider_16by8 #(
  parameter int N = 16,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  q_w;
  logic [D:0]    r_w;
  logic [D-1:0]  dvs_w;
  logic [CW-1:0] cnt;

  logic [D:0]    trial;
  logic          fit;
  logic [D:0]    r_next;
  logic [N-1:0]  q_next;

  // One restoring step; r_w[D] can never be set, but if it were the trial value would exceed any divisor
  always_comb begin
    trial  = {r_w[D-1:0], q_w[N-1]};
    fit    = r_w[D] | (trial >= {1'b0, dvs_w});
    r_next = fit ? (trial - {1'b0, dvs_w}) : trial;
    q_next = {q_w[N-2:0], fit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_w         <= '0;
      r_w         <= '0;
      dvs_w       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvs_w <= divisor;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[D-1:0];
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              q_w   <= dividend;
              r_w   <= '0;
              cnt   <= CW'(N);
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_w <= q_next;
          r_w <= r_next;
          cnt <= cnt - 1'b1;
          // Last iteration: publish the result on the way into DONE
          if (cnt == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= r_next[D-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed corner cases, handshake/reset behaviour,
// and a randomized back-to-back run compared against plain integer division.
module tb_seq_divider_16by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] lastQ = '0;
  logic [7:0]  lastR = '0;
  logic        lastZ = 1'b0;

  seq_divider_16by8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic modelDiv(input logic [15:0] a, input logic [7:0] b,
                          output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      z = 1'b0;
    end
  endtask

  // Starts one operation; returns one sample point (#1 after the accepting edge)
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Waits for done, counting cycles since acceptance and watching the held outputs
  task automatic waitDone(input int startLat, output int lat, output logic stableOk);
    lat      = startLat;
    stableOk = 1'b1;
    while (!done && lat < 40) begin
      if (quotient !== lastQ || remainder !== lastR || div_by_zero !== lastZ) stableOk = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [15:0] a, input logic [7:0] b,
                             input int lat, input logic stableOk);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    modelDiv(a, b, eq, er, ez);
    checkOutput({tag, "_latency"}, 32'(lat), (b == 8'd0) ? 32'd1 : 32'd17);
    checkOutput({tag, "_quotient"}, 32'(quotient), 32'(eq));
    checkOutput({tag, "_remainder"}, 32'(remainder), 32'(er));
    checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    checkOutput({tag, "_held_outputs"}, 32'(stableOk), 32'd1);
    lastQ = eq;
    lastR = er;
    lastZ = ez;
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [7:0] b);
    int   lat;
    logic ok;
    applyStimulus(a, b);
    waitDone(1, lat, ok);
    checkResult(tag, a, b, lat, ok);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat;
    logic        ok;
    logic        sawDone;
    logic [15:0] curA, nextA;
    logic [7:0]  curB, nextB;
    logic        curMul, nextMul;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_quotient", 32'(quotient), 32'd0);
    checkOutput("rst_remainder", 32'(remainder), 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("d1000_7", 16'd1000, 8'd7);
    checkOutput("d1000_7_q_const", 32'(quotient), 32'd142);
    checkOutput("d1000_7_r_const", 32'(remainder), 32'd6);
    runOp("d65535_1", 16'hFFFF, 8'd1);
    runOp("d65535_255", 16'hFFFF, 8'd255);
    checkOutput("d65535_255_q_const", 32'(quotient), 32'd257);
    runOp("d5_200", 16'd5, 8'd200);
    runOp("dzero", 16'h1234, 8'd0);
    checkOutput("dzero_r_const", 32'(remainder), 32'h34);

    // A start pulse during CALC must be ignored entirely
    applyStimulus(16'd1000, 8'd7);
    repeat (4) begin @(posedge clk); #1; end
    start    = 1'b1;
    dividend = 16'd300;
    divisor  = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ignored_start_busy", 32'(busy), 32'd1);
    waitDone(6, lat, ok);
    checkResult("ignored_start", 16'd1000, 8'd7, lat, ok);
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("ignored_start_not_queued", 32'(sawDone), 32'd0);

    // Asynchronous reset in CALC cycle 8 clears everything and suppresses done
    applyStimulus(16'd50000, 8'd13);
    repeat (7) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_quotient", 32'(quotient), 32'd0);
    checkOutput("async_rst_remainder", 32'(remainder), 32'd0);
    checkOutput("async_rst_dbz", 32'(div_by_zero), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lastQ = '0;
    lastR = '0;
    lastZ = 1'b0;
    sawDone = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("no_done_after_rst", 32'(sawDone), 32'd0);
    runOp("after_rst", 16'd50000, 8'd13);

    // Back-to-back run with start held high and operands for the next job presented early
    genOp(curA, curB, curMul);
    start    = 1'b1;
    dividend = curA;
    divisor  = curB;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      genOp(nextA, nextB, nextMul);
      dividend = nextA;
      divisor  = nextB;
      waitDone(1, lat, ok);
      checkResult("rnd", curA, curB, lat, ok);
      if (curMul) begin
        checkOutput("rnd_mul_quotient", 32'(quotient), 32'(curA) / 32'(curB));
        checkOutput("rnd_mul_remainder", 32'(remainder), 32'd0);
      end
      if (curB != 8'd0) begin
        checkOutput("rnd_invariant", 32'(quotient) * 32'(curB) + 32'(remainder), 32'(curA));
        checkOutput("rnd_rem_lt_div", 32'(remainder < curB), 32'd1);
      end
      if (i == 39) start = 1'b0;
      @(posedge clk); #1;
      checkOutput("rnd_idle_gap", 32'(busy), 32'd0);
      @(posedge clk); #1;
      if (i < 39) checkOutput("rnd_relaunch", 32'(busy), 32'd1);
      curA   = nextA;
      curB   = nextB;
      curMul = nextMul;
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Mix of zero divisors, exact products a*b, and arbitrary operands
  task automatic genOp(output logic [15:0] a, output logic [7:0] b, output logic isMul);
    int sel;
    logic [15:0] f;
    sel   = int'($urandom_range(0, 9));
    isMul = 1'b0;
    if (sel == 0) begin
      a = 16'($urandom);
      b = 8'd0;
    end else if (sel < 6) begin
      f     = 16'($urandom_range(0, 255));
      b     = 8'($urandom_range(1, 255));
      a     = f * {8'd0, b};
      isMul = 1'b1;
    end else begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
    end
  endtask

endmodule
